// File: rtl/ps2_pkg.sv
// ps2_pkg: scan codes, decoder FSM states and direction codes shared by the PS/2 direction path.
package ps2_pkg;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_BRK    = 8'hF0;
  localparam logic [7:0] SC_FSHIFT = 8'h12;
  localparam logic [7:0] SC_UP     = 8'h75;
  localparam logic [7:0] SC_RIGHT  = 8'h74;
  localparam logic [7:0] SC_DOWN   = 8'h72;
  localparam logic [7:0] SC_LEFT   = 8'h6B;
  localparam logic [7:0] SC_W      = 8'h1D;
  localparam logic [7:0] SC_D      = 8'h23;
  localparam logic [7:0] SC_S      = 8'h1B;
  localparam logic [7:0] SC_A      = 8'h1C;

  localparam logic [2:0] DIR_NONE  = 3'd0;
  localparam logic [2:0] DIR_UP    = 3'd1;
  localparam logic [2:0] DIR_RIGHT = 3'd2;
  localparam logic [2:0] DIR_DOWN  = 3'd3;
  localparam logic [2:0] DIR_LEFT  = 3'd4;

  typedef enum logic [1:0] {IDLE, EXT, BREAK, EXT_BREAK} state_t;

  // Flag vectors are ordered {left, down, right, up}, so direction code d maps to bit d-1.
  function automatic logic [3:0] dir_mask(input logic [2:0] d);
    return (d == DIR_NONE || d > DIR_LEFT) ? 4'b0000 : 4'b0001 << (d - 3'd1);
  endfunction

  function automatic logic [2:0] arrow_dir(input logic [7:0] b);
    return b == SC_UP ? DIR_UP : b == SC_RIGHT ? DIR_RIGHT :
           b == SC_DOWN ? DIR_DOWN : b == SC_LEFT ? DIR_LEFT : DIR_NONE;
  endfunction

  function automatic logic [2:0] letter_dir(input logic [7:0] b);
    return b == SC_W ? DIR_UP : b == SC_D ? DIR_RIGHT :
           b == SC_S ? DIR_DOWN : b == SC_A ? DIR_LEFT : DIR_NONE;
  endfunction
endpackage

// File: rtl/ps2_dir_arbiter.sv
// ps2_dir_arbiter: last-pressed-wins direction select with up > right > down > left fallback.
module ps2_dir_arbiter
  import ps2_pkg::*;
(
  input  logic [3:0] held,
  input  logic [2:0] last,
  output logic [2:0] dir_code
);
  assign dir_code = |(held & dir_mask(last)) ? last :
                    held[0] ? DIR_UP : held[1] ? DIR_RIGHT :
                    held[2] ? DIR_DOWN : held[3] ? DIR_LEFT : DIR_NONE;
endmodule

// File: rtl/ps2_direction_decoder.sv
// ps2_direction_decoder: PS/2 scan codes -> held arrow flags and encoded direction.
// Define PS2_WASD_KEYS_EN to also accept W/A/S/D as direction sources.
module ps2_direction_decoder
  import ps2_pkg::*;
#(
  parameter int PREFIX_TIMEOUT = 50000,
  parameter int TO_W = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_key_pressed,
  input  logic [7:0] ps2_out,
  output logic       upSig,
  output logic       rightSig,
  output logic       downSig,
  output logic       leftSig,
  output logic [2:0] dir_code,
  output logic       code_err
);
  state_t st, st_n;
  logic [TO_W-1:0] cnt, cnt_n;
  logic [3:0] a, a_n, held, held_n;
  logic [2:0] last, last_n, ad, dir_n;
  logic err_n;
  assign ad = arrow_dir(ps2_out);
`ifdef PS2_WASD_KEYS_EN
  logic [3:0] w, w_n;
  logic [2:0] ld;
  assign ld = letter_dir(ps2_out);
  assign held = a | w;
  assign held_n = a_n | w_n;
`else
  assign held = a;
  assign held_n = a_n;
`endif
  assign {leftSig, downSig, rightSig, upSig} = held;

  always_comb begin
    st_n = st;
    cnt_n = cnt;
    a_n = a;
    last_n = last;
    err_n = 1'b0;
`ifdef PS2_WASD_KEYS_EN
    w_n = w;
`endif
    if (ps2_key_pressed) begin
      cnt_n = '0;
      case (st)
        IDLE: begin
          st_n = ps2_out == SC_EXT ? EXT : ps2_out == SC_BRK ? BREAK : IDLE;
`ifdef PS2_WASD_KEYS_EN
          if (ld != DIR_NONE) begin
            w_n = w | dir_mask(ld);
            last_n = ld;
          end
`endif
        end
        EXT: begin
          st_n = ps2_out == SC_BRK ? EXT_BREAK : IDLE;
          if (ad != DIR_NONE) begin
            a_n = a | dir_mask(ad);
            last_n = ad;
          end
          err_n = ad == DIR_NONE && ps2_out != SC_BRK && ps2_out != SC_FSHIFT;
        end
        BREAK: begin
          st_n = ps2_out == SC_BRK ? BREAK : IDLE;
`ifdef PS2_WASD_KEYS_EN
          w_n = w & ~dir_mask(ld);
`endif
        end
        default: begin
          st_n = IDLE;
          a_n = a & ~dir_mask(ad);
          err_n = ad == DIR_NONE && ps2_out != SC_FSHIFT;
        end
      endcase
    end else if (st != IDLE) begin
      // A stalled prefix gives up so a lost byte cannot poison the next key.
      if (cnt == TO_W'(PREFIX_TIMEOUT - 1)) begin
        st_n = IDLE;
        cnt_n = '0;
        err_n = 1'b1;
      end else begin
        cnt_n = cnt + 1'b1;
      end
    end
  end

  ps2_dir_arbiter arb (.held(held_n), .last(last_n), .dir_code(dir_n));

  always_ff @(posedge clock) begin
    if (reset) begin
      st <= IDLE;
      cnt <= '0;
      a <= '0;
      last <= DIR_NONE;
      dir_code <= DIR_NONE;
      code_err <= 1'b0;
`ifdef PS2_WASD_KEYS_EN
      w <= '0;
`endif
    end else begin
      st <= st_n;
      cnt <= cnt_n;
      a <= a_n;
      last <= last_n;
      dir_code <= dir_n;
      code_err <= err_n;
`ifdef PS2_WASD_KEYS_EN
      w <= w_n;
`endif
    end
  end
endmodule

// File: tb/tb_ps2_direction_decoder.sv
// tb_ps2_direction_decoder: directed scan-code sequences with hand-computed flags, dir_code and code_err.
module tb_ps2_direction_decoder;
  localparam int P = 40;
  logic clock = 1'b0;
  logic reset, ps2_key_pressed;
  logic [7:0] ps2_out;
  logic upSig, rightSig, downSig, leftSig, code_err;
  logic [2:0] dir_code;
  logic [3:0] flags;
  int n_chk = 0;
  int n_fail = 0;

  assign flags = {leftSig, downSig, rightSig, upSig};

  ps2_direction_decoder #(.PREFIX_TIMEOUT(P), .TO_W(16)) dut (
    .clock(clock), .reset(reset), .ps2_key_pressed(ps2_key_pressed), .ps2_out(ps2_out),
    .upSig(upSig), .rightSig(rightSig), .downSig(downSig), .leftSig(leftSig),
    .dir_code(dir_code), .code_err(code_err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clock);
    ps2_key_pressed = 1'b1;
    ps2_out = b;
    @(negedge clock);
    ps2_key_pressed = 1'b0;
  endtask

  task automatic expect_out(input string tag, input logic [3:0] f, input logic [2:0] d, input logic e);
    chk({tag, ".flags"}, {4'h0, flags}, {4'h0, f});
    chk({tag, ".dir"}, {5'h0, dir_code}, {5'h0, d});
    chk({tag, ".err"}, {7'h0, code_err}, {7'h0, e});
  endtask

  initial begin
    reset = 1'b1;
    ps2_key_pressed = 1'b0;
    ps2_out = 8'h00;
    repeat (2) @(negedge clock);
    expect_out("reset", 4'b0000, 3'd0, 1'b0);
    reset = 1'b0;

    send(8'hE0);
    @(negedge clock);
    reset = 1'b1; ps2_key_pressed = 1'b1; ps2_out = 8'h75;
    @(negedge clock);
    reset = 1'b0; ps2_key_pressed = 1'b0;
    expect_out("rst_mid", 4'b0000, 3'd0, 1'b0);
    send(8'h75);
    expect_out("rst_lone75", 4'b0000, 3'd0, 1'b0);

    send(8'hE0);
    expect_out("up_prefix", 4'b0000, 3'd0, 1'b0);
    send(8'h75);
    expect_out("up_make", 4'b0001, 3'd1, 1'b0);
    send(8'hE0); send(8'hF0); send(8'h75);
    expect_out("up_break", 4'b0000, 3'd0, 1'b0);

    send(8'hE0); send(8'h75);
    send(8'hE0); send(8'h74);
    expect_out("ov_right", 4'b0011, 3'd2, 1'b0);
    send(8'hE0); send(8'hF0); send(8'h74);
    expect_out("ov_rel_right", 4'b0001, 3'd1, 1'b0);
    send(8'hE0); send(8'hF0); send(8'h75);
    expect_out("ov_rel_up", 4'b0000, 3'd0, 1'b0);

    send(8'hE0); send(8'h72);
    send(8'hE0); send(8'h6B);
    expect_out("fb_left", 4'b1100, 3'd4, 1'b0);
    send(8'hE0); send(8'h74);
    expect_out("fb_right", 4'b1110, 3'd2, 1'b0);
    send(8'hE0); send(8'hF0); send(8'h74);
    expect_out("fb_prio_down", 4'b1100, 3'd3, 1'b0);
    send(8'hE0); send(8'hF0); send(8'h72);
    expect_out("fb_left_only", 4'b1000, 3'd4, 1'b0);
    send(8'hE0); send(8'hF0); send(8'h72);
    expect_out("brk_not_held", 4'b1000, 3'd4, 1'b0);
    send(8'hE0); send(8'hF0); send(8'h6B);
    expect_out("fb_none", 4'b0000, 3'd0, 1'b0);

    send(8'hE0); send(8'h3C);
    expect_out("ext_err", 4'b0000, 3'd0, 1'b1);
    @(negedge clock);
    chk("ext_err_pulse", {7'h0, code_err}, 8'h00);
    send(8'hE0); send(8'h12);
    expect_out("ext_fshift", 4'b0000, 3'd0, 1'b0);
    send(8'hE0); send(8'hF0); send(8'h3C);
    expect_out("extbrk_err", 4'b0000, 3'd0, 1'b1);

    send(8'hE0);
    repeat (P - 1) @(negedge clock);
    chk("to_early", {7'h0, code_err}, 8'h00);
    @(negedge clock);
    chk("to_fire", {7'h0, code_err}, 8'h01);
    @(negedge clock);
    chk("to_pulse", {7'h0, code_err}, 8'h00);
    send(8'h75);
    expect_out("to_lone75", 4'b0000, 3'd0, 1'b0);

    send(8'hF0); send(8'hF0); send(8'h75);
    expect_out("brk_f0f0", 4'b0000, 3'd0, 1'b0);

    send(8'hE0); send(8'h6B);
    expect_out("nx_left", 4'b1000, 3'd4, 1'b0);
    send(8'hF0); send(8'h6B);
    expect_out("nx_brk_keep", 4'b1000, 3'd4, 1'b0);
`ifdef PS2_WASD_KEYS_EN
    send(8'h1C);
    expect_out("wasd_a", 4'b1000, 3'd4, 1'b0);
    send(8'hF0); send(8'h1C);
    expect_out("wasd_a_rel", 4'b1000, 3'd4, 1'b0);
    send(8'hE0); send(8'hF0); send(8'h6B);
    expect_out("wasd_arrow_rel", 4'b0000, 3'd0, 1'b0);
    send(8'h1D);
    expect_out("wasd_w", 4'b0001, 3'd1, 1'b0);
    send(8'hF0); send(8'h1D);
    expect_out("wasd_w_rel", 4'b0000, 3'd0, 1'b0);
`else
    send(8'hE0); send(8'hF0); send(8'h6B);
    expect_out("nx_arrow_rel", 4'b0000, 3'd0, 1'b0);
    send(8'h1D);
    expect_out("letter_ignored", 4'b0000, 3'd0, 1'b0);
`endif

    for (int i = 0; i < 5; i++) begin
      send(8'hE0); send(8'h75);
      expect_out("typematic", 4'b0001, 3'd1, 1'b0);
    end
    send(8'hE0); send(8'hF0); send(8'h75);
    expect_out("typematic_rel", 4'b0000, 3'd0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ps2_direction_decoder.md
Name: ps2_direction_decoder

Overview:
- Upstream stage of the processor skeleton's memory-mapped direction port (address 4100).
- Consumes raw PS/2 scan-code bytes (ps2_out, strobed by ps2_key_pressed) from the PS/2 controller.
- Tracks make/break state of the four arrow keys and drives the level signals upSig/rightSig/downSig/leftSig plus an encoded direction.
- The encoding matches the skeleton's load codes: 0 none, 1 up, 2 right, 3 down, 4 left.

Parameters:
- PREFIX_TIMEOUT, 50000: clock cycles a prefix state (EXT/BREAK/EXT_BREAK) may wait for its next byte before returning to IDLE.
- TO_W, 16: width of the timeout counter; must satisfy 2^TO_W > PREFIX_TIMEOUT.

Ports:
- clock  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- ps2_key_pressed  in  1  one-cycle strobe; ps2_out holds a new byte this cycle.
- ps2_out  in  8  received scan-code byte.
- upSig  out  1  up arrow currently held.
- rightSig  out  1  right arrow currently held.
- downSig  out  1  down arrow currently held.
- leftSig  out  1  left arrow currently held.
- dir_code  out  3  0 none, 1 up, 2 right, 3 down, 4 left (last-pressed-wins arbitration).
- code_err  out  1  one-cycle pulse on an unexpected byte in a prefix state, or on a timeout.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, timeout counter 0, last-pressed register 0. Reset dominates a coincident strobe.
- All outputs are registered. A flag changes in the cycle after the strobe carrying the final byte of its sequence. dir_code updates in the same cycle as the flags.
- FSM transitions (evaluated only on strobe cycles, except for timeout):
  - IDLE: E0 -> EXT; F0 -> BREAK; any other byte stays IDLE with no effect (E1 and non-arrow makes are ignored).
  - EXT: F0 -> EXT_BREAK; 75/74/72/6B set up/right/down/left and record that key as last-pressed, then -> IDLE; 12 (fake shift) -> IDLE silently; anything else -> IDLE with code_err.
  - BREAK: F0 stays BREAK; any other byte -> IDLE. A non-extended break never clears arrows.
  - EXT_BREAK: 75/74/72/6B clear the matching flag -> IDLE; 12 -> IDLE silently; anything else -> IDLE with code_err.
- Typematic repeat of a make code is idempotent; it re-records that key as last-pressed.
- A break for a key not held is a no-op.
- Timeout: the counter resets on every strobe and increments each cycle while in a prefix state. At PREFIX_TIMEOUT it forces IDLE and pulses code_err. Flags are untouched.
- dir_code arbitration:
  - If the last-pressed key is still held, output its code.
  - Otherwise, output the first held key in fixed priority up > right > down > left.
  - If none are held, output 0.
  - When the last-pressed key is released, the fallback takes effect in the same cycle the flag clears.
- Flags are independent; several may be 1 at once. The skeleton treats that as "no new code", so dir_code is the only unambiguous output.

Optional Feature:
- Macro: PS2_WASD_KEYS_EN.
- Defined: in IDLE, 1D/23/1B/1C (W/D/S/A) set up/right/down/left. Non-extended break (F0 then 1D/23/1B/1C) clears the matching flag.
  - Each direction is the OR of its arrow and letter sources, tracked separately. Releasing one source keeps the flag set while the other is still held.
  - Last-pressed recording applies to both sources.
- Undefined: letter codes are ignored exactly as any other non-extended byte.

Decomposition:
- Shared package ps2_pkg: scan-code constants (E0, F0, 12, 75, 74, 72, 6B, 1D, 23, 1B, 1C), the FSM state enum (IDLE, EXT, BREAK, EXT_BREAK), and direction-code constants 0–4. The skeleton's compare values reuse the same direction constants.
- One natural sub-module: ps2_dir_arbiter (held flags + last-pressed -> dir_code, purely combinational). It is instantiated once and registered in the parent.

Test Plan:
- Reset mid-sequence: strobe E0, then assert reset alongside strobe 75 -> all flags 0, dir_code 0, state IDLE; the next strobed 75 alone sets nothing.
- Arrow make/break: E0 75 -> upSig=1, dir_code=1 one cycle after the 75 strobe; then E0 F0 75 -> upSig=0, dir_code=0.
- Overlap arbitration: press up (E0 75), then right (E0 74) -> dir_code=2; release right (E0 F0 74) -> dir_code=1; release up -> 0.
- Error and timeout: E0 then 3C -> code_err pulse, no flag change; E0 with no further strobe for PREFIX_TIMEOUT cycles -> code_err pulse and IDLE; a following lone 75 sets nothing.
- Non-extended break: hold left (E0 6B), send F0 6B -> leftSig stays 1. With PS2_WASD_KEYS_EN, additionally send 1C then F0 1C -> leftSig stays 1 until E0 F0 6B.
- Typematic repeat: send E0 75 five times, then one E0 F0 75 -> upSig=1 throughout, then 0 after the single break.
